dds_rom_reader: RTL

DDS_ROM_READER -- requirements
Module: dds_rom_reader

---
 rtl/dds_pkg.sv | 19 +
 rtl/dds_phase_acc.sv | 86 ++++++++
 rtl/dds_rom_reader.sv | 110 +++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS wave-table reader: FSM state type,
// default widths and the DAC midscale code.
package dds_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } dds_state_e;

   localparam int DDS_ADDR_W  = 10;
   localparam int DDS_DATA_W  = 8;
   localparam int DDS_PHASE_W = 32;

   // Offset-binary zero for the default 8-bit DAC.
   localparam logic [DDS_DATA_W-1:0] DAC_MID = 8'h80;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with a shadowed tuning word. While running, a new
// tuning word is held back and swapped in on the clock after a wrap so the
// frequency change lands at a phase-continuous point of the waveform.
module dds_phase_acc
   import dds_pkg::*;
#(
   parameter int PHASE_WIDTH = DDS_PHASE_W,
   parameter int ADDR_WIDTH  = DDS_ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   input  logic [PHASE_WIDTH-1:0] fword,
   input  logic                   fword_load,
   output logic [ADDR_WIDTH-1:0]  phase_msb,
   output logic                   wrap
);

   logic [PHASE_WIDTH-1:0] acc_q, acc_d;
   logic [PHASE_WIDTH-1:0] active_q, active_d;
   logic [PHASE_WIDTH-1:0] shadow_q, shadow_d;
   logic                   pending_q, pending_d;
   logic                   wrap_q, wrap_d;
   logic [PHASE_WIDTH-1:0] step;
   logic [PHASE_WIDTH:0]   sum;

   // Next-state: accumulate while running, park at zero otherwise; manage shadow word.
   always_comb begin
      acc_d     = acc_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      wrap_d    = 1'b0;
      step      = active_q;
      sum       = '0;
      if (run) begin
         // A pending word is applied on the clock right after the wrap pulse,
         // and this very addition already uses it.
         if (wrap_q && pending_q) begin
            step      = shadow_q;
            active_d  = shadow_q;
            pending_d = 1'b0;
         end
         sum    = {1'b0, acc_q} + {1'b0, step};
         acc_d  = sum[PHASE_WIDTH-1:0];
         wrap_d = sum[PHASE_WIDTH];
         // A load on the swap clock re-arms the shadow for the following wrap.
         if (fword_load) begin
            shadow_d  = fword;
            pending_d = 1'b1;
         end
      end else begin
         acc_d = '0;
         // Nothing to stay phase-continuous with: commit any held word now.
         if (pending_q) begin
            active_d = shadow_q;
         end
         pending_d = 1'b0;
         if (fword_load) begin
            active_d = fword;
            shadow_d = fword;
         end
      end
   end

   // Accumulator, tuning-word and wrap registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         wrap_q    <= wrap_d;
      end
   end

   assign phase_msb = acc_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
   assign wrap      = wrap_q;

endmodule

// File: rtl/dds_rom_reader.sv
// DDS front end: run/park FSM, wave-table address generation and the
// amplitude-scaled, offset-binary DAC output register.
module dds_rom_reader
   import dds_pkg::*;
#(
   parameter int ADDR_WIDTH  = DDS_ADDR_W,
   parameter int DATA_WIDTH  = DDS_DATA_W,
   parameter int PHASE_WIDTH = DDS_PHASE_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [PHASE_WIDTH-1:0] fword,
   input  logic                   fword_load,
   input  logic [ADDR_WIDTH-1:0]  pword,
   input  logic [2:0]             amp_shift,
   output logic [ADDR_WIDTH-1:0]  rom_addr,
   input  logic [DATA_WIDTH-1:0]  rom_data,
   output logic [DATA_WIDTH-1:0]  dac_data,
   output logic                   sample_valid,
   output logic                   wrap
);

   localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

   // Attenuate around midscale: recentre to signed, arithmetic shift, re-offset.
   // The magnitude never grows, so the result always fits without clipping.
   function automatic logic [DATA_WIDTH-1:0] scale_sample(
      input logic [DATA_WIDTH-1:0] raw,
      input logic [2:0]            shift
   );
      logic signed [DATA_WIDTH:0] centred;
      logic signed [DATA_WIDTH:0] scaled;
      centred = $signed({1'b0, raw}) - $signed({1'b0, MID});
      scaled  = centred >>> shift;
      return DATA_WIDTH'($unsigned(scaled) + {1'b0, MID});
   endfunction

   dds_state_e              state_q, state_d;
   logic                    run;
   logic [ADDR_WIDTH-1:0]   phase_msb;
   logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
   logic                    vld_p0_q, vld_p0_d;
   logic                    vld_p1_q, vld_p1_d;
   logic                    vld_p2_q, vld_p2_d;
   logic [DATA_WIDTH-1:0]   dac_data_q, dac_data_d;

   assign run = (state_q == ST_PRIME) || (state_q == ST_RUN);

   dds_phase_acc #(
      .PHASE_WIDTH (PHASE_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_phase_acc (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .fword      (fword),
      .fword_load (fword_load),
      .phase_msb  (phase_msb),
      .wrap       (wrap)
   );

   // Next-state logic: one PRIME clock on entry, one DRAIN clock on exit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (en)  state_d = ST_PRIME;
         ST_PRIME:          state_d = ST_RUN;
         ST_RUN:   if (!en) state_d = ST_DRAIN;
         ST_DRAIN:          state_d = ST_IDLE;
         default:           state_d = ST_IDLE;
      endcase
   end

   // Datapath: address (p0), ROM read (p1), scaled sample (p2); valid rides alongside.
   always_comb begin
      // p0: address issued; only PRIME/RUN addresses feed real samples
      rom_addr_d = phase_msb + pword;
      vld_p0_d   = run;
      // p1: ROM data for the p0 address arrives one clock later
      vld_p1_d   = vld_p0_q;
      // p2: output register, midscale whenever no real sample is present
      vld_p2_d   = vld_p1_q;
      dac_data_d = vld_p1_q ? scale_sample(rom_data, amp_shift) : MID;
   end

   // State and pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rom_addr_q <= '0;
         vld_p0_q   <= 1'b0;
         vld_p1_q   <= 1'b0;
         vld_p2_q   <= 1'b0;
         dac_data_q <= MID;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         vld_p0_q   <= vld_p0_d;
         vld_p1_q   <= vld_p1_d;
         vld_p2_q   <= vld_p2_d;
         dac_data_q <= dac_data_d;
      end
   end

   assign rom_addr     = rom_addr_q;
   assign dac_data     = dac_data_q;
   assign sample_valid = vld_p2_q;

endmodule
